// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
//   Shared types and constants for the instruction-fetch stage.
//   - FS_DATA_W / BRANCH_DATA_W : widths of the fetch->decode payload and of the
//     branch bundle coming back from decode.
//   - FETCH_RESET_PC            : default address of the first fetch after reset.
//   - fs_state_e                : fetch FSM encoding (2-bit).
//   - fs_data_t / branch_data_t : packed views of the two wide buses.
//   - word_align()              : clears the byte-offset bits of an address.
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

    localparam int          FS_DATA_W       = 64;
    localparam int          BRANCH_DATA_W   = 33;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,   // first cycle out of reset, nothing issued yet
        FS_REQ  = 2'd1,   // request on the bus, waiting for ready
        FS_WAIT = 2'd2,   // request accepted, waiting for the response word
        FS_HOLD = 2'd3    // word parked in the skid buffer while decode stalls
    } fs_state_e;

    // {instr, pc} as presented to decode
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fs_data_t;

    // {branch_addr, branch_control} as driven by decode
    typedef struct packed {
        logic [31:0] addr;
        logic        ctrl;
    } branch_data_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & WORD_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
//   One-entry holding register for a fetched {instr, pc} that arrived while
//   decode was stalled and the fetch/decode register could not take it.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     load       : capture din, entry becomes valid
//     drain      : entry has been moved to the fetch/decode register
//     clear      : discard the entry (wrong path after a redirect)
//     din        : {instr, pc} to park
//     valid      : entry holds a word
//     dout       : parked {instr, pc}
//   clear and drain win over load.
// -----------------------------------------------------------------------------
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 drain,
    input  logic                 clear,
    input  logic [FS_DATA_W-1:0] din,
    output logic                 valid,
    output logic [FS_DATA_W-1:0] dout
);

    logic                 valid_q, valid_d;
    logic [FS_DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear || drain) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the PC, issues one word fetch at a time over
//   a valid/ready request channel with a separate response-valid channel, and
//   loads the fetch/decode register {instr, pc}. Honours decode's load-use
//   stall and branch redirects; every wrong-path word is discarded.
//   Ports:
//     clk, rst_n       : clock, asynchronous active-low reset
//     ds_branch_data   : {branch_addr[31:0], branch_control} from decode
//     load_use         : decode stall, fetch/decode register must hold
//     imem_req_valid   : fetch request valid
//     imem_req_ready   : memory accepts the request this cycle
//     imem_addr        : word address of the request
//     imem_resp_valid  : response word valid (at most one outstanding)
//     imem_resp_data   : instruction word
//     fs_valid         : fs_ds_reg_data holds a real instruction
//     fs_ds_reg_data   : {instr, pc} to decode
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BRANCH_DATA_W-1:0] ds_branch_data,
    input  logic                     load_use,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_addr,
    input  logic                     imem_resp_valid,
    input  logic [31:0]              imem_resp_data,
    output logic                     fs_valid,
    output logic [FS_DATA_W-1:0]     fs_ds_reg_data
);

    fs_state_e    state_q, state_d;
    logic [31:0]  pc_next_q, pc_next_d;
    logic [31:0]  req_pc_q,  req_pc_d;
    logic         kill_q,    kill_d;
    logic         fs_valid_q, fs_valid_d;
    fs_data_t     fs_data_q,  fs_data_d;

    branch_data_t br;
    logic [31:0]  branch_target;
    logic [31:0]  fetch_base;
    logic         consume;
    logic         redirect;
    logic         resp_in_wait;
    logic         enter_req;
    logic         load_resp;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_valid;
    fs_data_t     skid_data;
    fs_data_t     resp_word;

    // Decode's branch/stall inputs only mean something while it holds a valid
    // instruction, so both are gated with fs_valid here.
    assign br            = ds_branch_data;
    assign branch_target = word_align(br.addr);
    assign consume       = fs_valid_q & ~load_use;
    assign redirect      = consume & br.ctrl;

    assign resp_in_wait  = (state_q == FS_WAIT) && imem_resp_valid;
    assign resp_word     = '{instr: imem_resp_data, pc: req_pc_q};

    // A fresh request starts whenever the FSM moves into REQ from elsewhere.
    // If a redirect happens in that same cycle the new request goes straight
    // to the branch target.
    assign enter_req     = (state_d == FS_REQ) && (state_q != FS_REQ);
    assign fetch_base    = redirect ? branch_target : pc_next_q;

    // Word goes straight to decode when the register is free or being consumed;
    // otherwise it is parked. A killed or redirected word goes nowhere.
    assign load_resp  = resp_in_wait && !kill_q && !redirect && (!fs_valid_q || consume);
    assign skid_load  = resp_in_wait && !kill_q && !redirect && fs_valid_q && load_use;
    assign skid_drain = (state_q == FS_HOLD) && !load_use && !redirect && skid_valid;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (skid_load),
        .drain (skid_drain),
        .clear (redirect),
        .din   (resp_word),
        .valid (skid_valid),
        .dout  (skid_data)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            FS_IDLE: state_d = FS_REQ;
            FS_REQ: begin
                if (imem_req_ready) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (imem_resp_valid) begin
                    // Only a word that must be kept while decode stalls parks us in HOLD.
                    if (!kill_q && !redirect && fs_valid_q && load_use) begin
                        state_d = FS_HOLD;
                    end else begin
                        state_d = FS_REQ;
                    end
                end
            end
            FS_HOLD: begin
                // Covers both the normal drain and a redirect (which implies ~load_use).
                if (!load_use) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        imem_req_valid = (state_q == FS_REQ);
        imem_addr      = req_pc_q;
        fs_valid       = fs_valid_q;
        fs_ds_reg_data = fs_data_q;
    end

    // ---------------- PC, kill flag and fetch/decode register ----------------
    always_comb begin
        pc_next_d  = pc_next_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;
        fs_valid_d = fs_valid_q;
        fs_data_d  = fs_data_q;

        if (enter_req) begin
            req_pc_d  = fetch_base;
            pc_next_d = fetch_base + PC_STEP;
        end else if (redirect) begin
            pc_next_d = branch_target;
        end

        // The response to a request already on the bus cannot be retracted, so a
        // redirect before it returns marks it to be dropped on arrival. A
        // response arriving together with the redirect is dropped directly.
        if (resp_in_wait) begin
            kill_d = 1'b0;
        end else if (redirect && (state_q == FS_REQ || state_q == FS_WAIT)) begin
            kill_d = 1'b1;
        end

        if (redirect) begin
            fs_valid_d = 1'b0;
        end else if (load_resp) begin
            fs_valid_d = 1'b1;
            fs_data_d  = resp_word;
        end else if (skid_drain) begin
            fs_valid_d = 1'b1;
            fs_data_d  = skid_data;
        end else if (consume) begin
            // Data keeps its last value; only the valid bit drops.
            fs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next_q  <= word_align(RESET_PC);
            req_pc_q   <= '0;
            kill_q     <= 1'b0;
            fs_valid_q <= 1'b0;
            fs_data_q  <= '0;
        end else begin
            pc_next_q  <= pc_next_d;
            req_pc_q   <= req_pc_d;
            kill_q     <= kill_d;
            fs_valid_q <= fs_valid_d;
            fs_data_q  <= fs_data_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [32:0] ds_branch_data;
    logic        load_use;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        fs_valid;
    logic [63:0] fs_ds_reg_data;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h8000_0000)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ds_branch_data  (ds_branch_data),
        .load_use        (load_use),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .fs_valid        (fs_valid),
        .fs_ds_reg_data  (fs_ds_reg_data)
    );

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    bit          lu;
    bit          bctl;
    logic [31:0] baddr;
    int          rdy_mode;   // 0 low, 1 high, 2 random
    int          lat_mode;   // 0 random 1..3, else fixed response latency
    bit          stale;      // force a spurious response this cycle

    // memory model
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] hs_log[$];

    // reference model: transaction view of the fetch stage
    bit          m_boot;     // first cycle out of reset, nothing issued
    bit          m_req;      // request presented on the bus
    logic [31:0] m_addr;     // address of the current / last request
    bit          m_wait;     // request accepted, response pending
    bit          m_wrong;    // pending response belongs to the wrong path
    bit          m_pend;     // a word waits for decode to unstall
    logic [63:0] m_pend_d;
    bit          m_fv;
    logic [63:0] m_fd;
    logic [31:0] m_pc;       // address of the next sequential fetch

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
    endfunction

    function automatic void model_reset();
        m_boot = 1; m_req = 0; m_addr = 0; m_wait = 0; m_wrong = 0;
        m_pend = 0; m_pend_d = 0; m_fv = 0; m_fd = 0; m_pc = 32'h8000_0000;
    endfunction

    function automatic void model_update();
        bit consume, redir, issue, loaded;
        logic [31:0] tgt, base;
        consume = m_fv && !lu;
        redir   = consume && bctl;
        tgt     = baddr & 32'hFFFF_FFFC;
        issue   = 0;
        loaded  = 0;
        if (m_boot) begin
            m_boot = 0;
            issue  = 1;
        end else if (m_req) begin
            if (redir) m_wrong = 1;
            if (imem_req_ready) begin m_req = 0; m_wait = 1; end
        end else if (m_wait) begin
            if (imem_resp_valid) begin
                m_wait = 0;
                issue  = 1;
                if (m_wrong) begin
                    m_wrong = 0;
                end else if (redir) begin
                    loaded = 0;   // word is on the abandoned path
                end else if (!m_fv || consume) begin
                    m_fd = {imem_resp_data, m_addr};
                    loaded = 1;
                end else begin
                    m_pend = 1;
                    m_pend_d = {imem_resp_data, m_addr};
                    issue = 0;
                end
            end else if (redir) begin
                m_wrong = 1;
            end
        end else if (m_pend) begin
            if (!lu) begin
                m_pend = 0;
                issue  = 1;
                if (!redir) begin m_fd = m_pend_d; loaded = 1; end
            end
        end
        if (redir)        m_fv = 0;
        else if (loaded)  m_fv = 1;
        else if (consume) m_fv = 0;
        if (issue) begin
            base   = redir ? tgt : m_pc;
            m_req  = 1;
            m_addr = base;
            m_pc   = base + 32'd4;
        end else if (redir) begin
            m_pc = tgt;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge.
    task automatic tick();
        bit          hs;
        logic [31:0] hs_addr;
        imem_req_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        ds_branch_data = {baddr, bctl};
        load_use       = lu;
        if (stale || mem_cnt == 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = stale ? $urandom : word_of(mem_addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(posedge clk);
        hs      = rst_n && m_req && imem_req_ready;
        hs_addr = m_addr;
        if (!rst_n) model_reset();
        else        model_update();
        if (imem_resp_valid)  mem_cnt = 0;
        else if (mem_cnt > 1) mem_cnt--;
        if (hs) begin
            mem_cnt  = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 3));
            mem_addr = hs_addr;
            hs_log.push_back(hs_addr);
        end
        @(negedge clk);
        chk("req_valid", imem_req_valid, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("fs_valid", fs_valid, m_fv);
        chk("fs_ds_data", fs_ds_reg_data, m_fd);
    endtask

    task automatic wait_fs_valid(input string tag, output int n);
        n = 0;
        while (fs_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk(tag, n < 40, 1);
    endtask

    task automatic wait_req_fv(input string tag);
        int n = 0;
        while (!(m_req && m_fv) && n < 40) begin tick(); n++; end
        chk(tag, n < 40, 1);
    endtask

    task automatic wait_hs(input string tag, input int cnt);
        int n = 0;
        while (hs_log.size() < cnt && n < 60) begin tick(); n++; end
        chk(tag, n < 60, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          c0;
        logic [31:0] a;
        logic [63:0] held;

        rst_n = 0; lu = 0; bctl = 0; baddr = 0; rdy_mode = 1; lat_mode = 1; stale = 0;
        mem_cnt = 0; mem_addr = 0;
        imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = 0;
        load_use = 0; ds_branch_data = 0;
        model_reset();

        // ---- 1: reset, then sequential fetch ----
        tick(); tick();
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_fs_valid", fs_valid, 0);
        chk("rst_fs_data", fs_ds_reg_data, 0);
        rst_n = 1;
        tick();
        chk("t1_first_req", imem_req_valid, 1);
        chk("t1_first_addr", imem_addr, 32'h8000_0000);
        wait_fs_valid("t1_fs_timeout", n);
        chk("t1_latency", n, 2);
        chk("t1_fs_data", fs_ds_reg_data, {word_of(32'h8000_0000), 32'h8000_0000});
        wait_hs("t1_hs_timeout", 3);
        chk("t1_addr0", hs_log[0], 32'h8000_0000);
        chk("t1_addr1", hs_log[1], 32'h8000_0004);
        chk("t1_addr2", hs_log[2], 32'h8000_0008);

        // ---- 2: load-use stall parks the word, then it drains ----
        wait_req_fv("t2_sync");
        a    = m_addr;
        held = m_fd;
        lu   = 1;
        tick();
        chk("t2_hold_a", fs_ds_reg_data, held);
        tick();
        chk("t2_hold_req", imem_req_valid, 0);
        chk("t2_hold_b", fs_ds_reg_data, held);
        tick();
        chk("t2_hold_c", fs_ds_reg_data, held);
        chk("t2_hold_fv", fs_valid, 1);
        lu = 0;
        tick();
        chk("t2_skid_data", fs_ds_reg_data, {word_of(a), a});
        chk("t2_skid_fv", fs_valid, 1);
        chk("t2_resume_addr", imem_addr, a + 32'd4);

        // ---- 3: redirect while waiting for the response ----
        lat_mode = 3;
        wait_req_fv("t3_sync");
        lu = 1;
        tick();
        lu = 0; bctl = 1; baddr = 32'h0000_1000;
        tick();
        bctl = 0;
        chk("t3_fv_cleared", fs_valid, 0);
        c0 = hs_log.size();
        wait_hs("t3_hs_timeout", c0 + 1);
        chk("t3_target_addr", hs_log[c0], 32'h0000_1000);
        wait_fs_valid("t3_fs_timeout", n);
        chk("t3_target_data", fs_ds_reg_data, {word_of(32'h0000_1000), 32'h0000_1000});

        // ---- 4: redirect in the same cycle as the response ----
        lat_mode = 2;
        wait_req_fv("t4_sync");
        lu = 1;
        tick();
        tick();
        lu = 0; bctl = 1; baddr = 32'h0000_1000;
        tick();
        bctl = 0;
        chk("t4_fv_cleared", fs_valid, 0);
        chk("t4_req_valid", imem_req_valid, 1);
        chk("t4_req_addr", imem_addr, 32'h0000_1000);
        wait_fs_valid("t4_fs_timeout", n);
        chk("t4_target_data", fs_ds_reg_data, {word_of(32'h0000_1000), 32'h0000_1000});

        // ---- 5: ready held low, redirect to an unaligned target mid-wait ----
        lat_mode = 1;
        wait_req_fv("t5_sync");
        rdy_mode = 0; lu = 1;
        a = m_addr;
        tick();
        chk("t5_stable_a", imem_addr, a);
        tick();
        chk("t5_stable_b", imem_addr, a);
        lu = 0; bctl = 1; baddr = 32'h0000_1002;
        tick();
        bctl = 0;
        chk("t5_fv_cleared", fs_valid, 0);
        chk("t5_stable_c", imem_addr, a);
        chk("t5_still_req", imem_req_valid, 1);
        tick();
        chk("t5_stable_d", imem_addr, a);
        rdy_mode = 1;
        c0 = hs_log.size();
        wait_hs("t5_hs_timeout", c0 + 2);
        chk("t5_completed_addr", hs_log[c0], a);
        chk("t5_target_addr", hs_log[c0 + 1], 32'h0000_1000);
        wait_fs_valid("t5_fs_timeout", n);
        chk("t5_target_data", fs_ds_reg_data, {word_of(32'h0000_1000), 32'h0000_1000});

        // ---- 6: asynchronous reset mid-wait, stale response, pc wrap ----
        lat_mode = 3;
        n = 0;
        while (!m_wait && n < 40) begin tick(); n++; end
        chk("t6_sync", n < 40, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_req", imem_req_valid, 0);
        chk("t6_async_addr", imem_addr, 0);
        chk("t6_async_fv", fs_valid, 0);
        chk("t6_async_data", fs_ds_reg_data, 0);
        model_reset();
        mem_cnt = 0;
        stale = 1;
        tick();
        rst_n = 1;
        tick();
        stale = 0;
        chk("t6_restart_req", imem_req_valid, 1);
        chk("t6_restart_addr", imem_addr, 32'h8000_0000);
        lat_mode = 1;
        wait_fs_valid("t6_fs_timeout", n);
        chk("t6_restart_data", fs_ds_reg_data, {word_of(32'h8000_0000), 32'h8000_0000});
        bctl = 1; baddr = 32'hFFFF_FFFF;
        tick();
        bctl = 0;
        c0 = hs_log.size();
        wait_hs("t6_hs_timeout", c0 + 2);
        chk("t6_wrap_top", hs_log[c0], 32'hFFFF_FFFC);
        chk("t6_wrap_zero", hs_log[c0 + 1], 32'h0000_0000);

        // ---- random traffic against the model ----
        rdy_mode = 2;
        lat_mode = 0;
        for (int i = 0; i < 2000; i++) begin
            lu    = ($urandom_range(0, 3) == 0);
            bctl  = ($urandom_range(0, 5) == 0);
            baddr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            tick();
        end
        lu = 0; bctl = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
